// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU/AXI definitions for the read front-end
package cpu_defs;

  localparam int AXI_ID_W = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  typedef struct packed {
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          burst;
  } ax_req_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_PENDING,
    CH_INFLIGHT
  } ch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal rotating pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          upd,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] ptr;
  int            idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // Scan from the pointer, wrapping, and take the first requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_mux.sv
// rtl/axi_rd_mux.sv - N-channel AXI read front-end: RR AR arbitration, rid routing
module axi_rd_mux
  import cpu_defs::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                LEN_W     = 8,
  parameter logic [NUM_CH-1:0] WRAP_MASK = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       rd_req,
  input  logic [NUM_CH*32-1:0]    rd_addr,
  input  logic [NUM_CH*LEN_W-1:0] rd_len,
  input  logic [NUM_CH*3-1:0]     rd_size,
  output logic [NUM_CH-1:0]       rd_rdy,
  output logic [NUM_CH-1:0]       ret_valid,
  output logic                    ret_last,
  output logic                    ret_err,
  output logic [31:0]             ret_data,
  output logic                    proto_err,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  ch_state_e         st_q [NUM_CH];
  ch_state_e         st_d [NUM_CH];
  logic [LEN_W-1:0]  cnt_q[NUM_CH];
  logic [LEN_W-1:0]  len_q[NUM_CH];
  logic [NUM_CH-1:0] busy, elig, gnt, hit;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any, slot_free, r_fire, drop, len_err;
  ax_req_t           ar_q, ar_d;
  logic              unused_resp;

  assign rready      = !reset;
  assign r_fire      = rvalid && rready;
  assign elig        = rd_req & ~busy;
  assign slot_free   = !arvalid || arready;
  assign rd_rdy      = gnt;
  assign unused_resp = rresp[0];

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .en      (slot_free),
    .upd     (gnt_any),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    ar_d.addr  = rd_addr[gnt_idx*32 +: 32];
    ar_d.len   = 8'(rd_len[gnt_idx*LEN_W +: LEN_W]);
    ar_d.size  = rd_size[gnt_idx*3 +: 3];
    ar_d.id    = AXI_ID_W'(gnt_idx);
    ar_d.burst = WRAP_MASK[gnt_idx] ? AXI_BURST_WRAP : AXI_BURST_INCR;
  end

  // A new grant may overwrite the register in the same cycle the old entry handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_q    <= '0;
      arvalid <= 1'b0;
    end else if (gnt_any) begin
      ar_q    <= ar_d;
      arvalid <= 1'b1;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;
  assign arburst = ar_q.burst;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) st_q[i] <= CH_IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) st_q[i] <= st_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        CH_IDLE:     if (gnt[i]) st_d[i] = CH_PENDING;
        CH_PENDING:  if (hit[i] && rlast) st_d[i] = CH_IDLE;
                     else if (arvalid && arready && ar_q.id == AXI_ID_W'(i)) st_d[i] = CH_INFLIGHT;
        CH_INFLIGHT: if (hit[i] && rlast) st_d[i] = CH_IDLE;
        default:     st_d[i] = CH_IDLE;
      endcase
    end
  end

  // Return routing and burst-length checking are purely combinational.
  always_comb begin
    busy    = '0;
    hit     = '0;
    len_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (st_q[i] != CH_IDLE);
      hit[i]  = r_fire && (rid == AXI_ID_W'(i)) && busy[i];
      if (hit[i] && (rlast != (cnt_q[i] == len_q[i]))) len_err = 1'b1;
    end
    drop      = r_fire && !(|hit);
    ret_valid = hit;
    ret_data  = rdata;
    ret_last  = rlast;
    ret_err   = rresp[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        len_q[i] <= '0;
      end
      proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt[i]) begin
          cnt_q[i] <= '0;
          len_q[i] <= rd_len[i*LEN_W +: LEN_W];
        end else if (hit[i]) begin
          cnt_q[i] <= cnt_q[i] + LEN_W'(1);
        end
      end
      proto_err <= proto_err | len_err | drop;
    end
  end

endmodule

// File: tb/tb_axi_rd_mux.sv
// tb/tb_axi_rd_mux.sv - scoreboard bench for axi_rd_mux with randomized traffic
module tb_axi_rd_mux;

  localparam logic [3:0] WMASK = 4'b0001;

  logic         clk, reset;
  logic [3:0]   rd_req;
  logic [127:0] rd_addr;
  logic [31:0]  rd_len;
  logic [11:0]  rd_size;
  logic [3:0]   rd_rdy, ret_valid;
  logic         ret_last, ret_err, proto_err;
  logic [31:0]  ret_data;
  logic [3:0]   arid, arcache;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, arlock;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  axi_rd_mux #(.NUM_CH(4), .LEN_W(8), .WRAP_MASK(WMASK)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_size(rd_size), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_err(ret_err), .ret_data(ret_data), .proto_err(proto_err), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic last; logic [1:0] resp; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [3:0] id; logic [1:0] burst; } ar_t;

  beat_t ret_q[$];
  ar_t   ar_exp[$];
  int    n_pass = 0, n_total = 0;
  logic [3:0] wrap_mask = WMASK;

  // Reference state: which channels hold a burst, beats seen, expected length, RR pointer.
  bit m_busy[4];
  int m_len[4], m_cnt[4];
  int m_ptr;
  bit m_arvalid, m_perr, just_rst;

  // Slave-side bookkeeping for the randomized phase.
  bit s_act[4];
  int s_len[4], s_sent[4];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void fail(string name);
    n_total++;
    $display("FAIL %s actual=missing expected=present at %0t", name, $time);
  endfunction

  always @(negedge clk) begin : monitor
    beat_t      b;
    ar_t        a;
    logic [3:0] elig, exp_rv, exp_gnt;
    int         w;
    if (reset) begin
      chk("rready_in_reset", rready, 0);
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 0; m_cnt[i] = 0; m_len[i] = 0;
      end
      m_ptr = 0; m_arvalid = 0; m_perr = 0; just_rst = 1;
      ar_exp.delete(); ret_q.delete();
    end else begin
      if (just_rst) begin
        chk("rst_arvalid", arvalid, 0);
        chk("rst_ar_fields", {araddr, arlen, arid, arsize, arburst}, 0);
        chk("rst_proto_err", proto_err, 0);
        just_rst = 0;
      end
      chk("rready", rready, 1);
      chk("proto_err", proto_err, m_perr);
      chk("arvalid", arvalid, m_arvalid);
      chk("ar_const", {arlock, arcache, arprot}, 0);
      if (m_arvalid) begin
        if (ar_exp.size() == 0) fail("ar_expect");
        else begin
          chk("araddr", araddr, ar_exp[0].addr);
          chk("arlen", arlen, ar_exp[0].len);
          chk("arsize", arsize, ar_exp[0].size);
          chk("arid", arid, ar_exp[0].id);
          chk("arburst", arburst, ar_exp[0].burst);
        end
      end
      for (int i = 0; i < 4; i++) elig[i] = rd_req[i] && !m_busy[i];
      exp_rv = '0;
      if (rvalid) begin
        if (ret_q.size() == 0) fail("ret_expect");
        else begin
          b = ret_q.pop_front();
          chk("ret_data", ret_data, b.data);
          chk("ret_last", ret_last, b.last);
          chk("ret_err", ret_err, b.resp[1]);
          if (b.id < 4 && m_busy[b.id]) begin
            exp_rv[b.id] = 1'b1;
            if (b.last != (m_cnt[b.id] == m_len[b.id])) m_perr = 1;
            m_cnt[b.id]++;
            if (b.last) m_busy[b.id] = 0;
          end else begin
            m_perr = 1;
          end
        end
      end
      chk("ret_valid", ret_valid, exp_rv);
      if (m_arvalid && arready) ar_exp.pop_front();
      exp_gnt = '0;
      w = -1;
      if (!m_arvalid || arready)
        for (int k = 0; k < 4; k++)
          if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin
        exp_gnt[w] = 1'b1;
        a.addr  = rd_addr[w*32 +: 32];
        a.len   = rd_len[w*8 +: 8];
        a.size  = rd_size[w*3 +: 3];
        a.id    = 4'(w);
        a.burst = wrap_mask[w] ? 2'b10 : 2'b01;
        ar_exp.push_back(a);
        m_busy[w] = 1; m_cnt[w] = 0; m_len[w] = int'(rd_len[w*8 +: 8]);
        m_ptr = (w + 1) % 4;
        m_arvalid = 1;
      end else if (arready) begin
        m_arvalid = 0;
      end
      chk("rd_rdy", rd_rdy, exp_gnt);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) s_act[i] = 0;
    end else if (arvalid && arready) begin
      s_act[arid] = 1; s_len[arid] = int'(arlen); s_sent[arid] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int ch, logic [31:0] a, logic [7:0] l, logic [2:0] s);
    rd_req[ch] = 1'b1;
    rd_addr[ch*32 +: 32] = a;
    rd_len[ch*8 +: 8] = l;
    rd_size[ch*3 +: 3] = s;
  endtask

  task automatic beat(int id, logic [31:0] d, logic last, logic [1:0] resp);
    beat_t bb;
    rvalid = 1'b1; rid = 4'(id); rdata = d; rlast = last; rresp = resp;
    bb.id = 4'(id); bb.data = d; bb.last = last; bb.resp = resp;
    ret_q.push_back(bb);
  endtask

  task automatic no_beat();
    rvalid = 1'b0; rid = '0; rlast = 1'b0; rresp = '0; rdata = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_req = '0; arready = 1'b0; no_beat();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic beats(int ids[$], bit lasts[$]);
    foreach (ids[j]) begin
      beat(ids[j], $urandom, lasts[j], 2'b00);
      tick();
    end
    no_beat();
    tick();
  endtask

  initial begin
    int cand[$];
    int pick;
    reset = 1'b1; rd_req = '0; rd_addr = '0; rd_len = '0; rd_size = '0; arready = 1'b0;
    no_beat();
    do_reset();

    // single channel burst
    arready = 1'b1;
    set_req(1, 32'h1fc0_0000, 8'd3, 3'd2);
    tick();
    rd_req = '0;
    tick();
    beats('{1, 1, 1, 1}, '{0, 0, 0, 1});
    chk("t1_proto_err", proto_err, 0);

    // round robin across all four, then returns out of order
    do_reset();
    arready = 1'b1;
    for (int c = 0; c < 4; c++) set_req(c, 32'h1000 * c, 8'd0, 3'd2);
    repeat (6) tick();
    rd_req = '0;
    beats('{2, 0, 3, 1}, '{1, 1, 1, 1});
    for (int c = 0; c < 4; c++) set_req(c, 32'h2000 + 32'h40 * c, 8'd0, 3'd2);
    repeat (5) tick();
    rd_req = '0;
    beats('{0, 1, 2, 3}, '{1, 1, 1, 1});

    // AR backpressure holds fields and blocks further grants
    do_reset();
    set_req(0, 32'h3000, 8'd1, 3'd2);
    tick();
    set_req(1, 32'h3100, 8'd0, 3'd1);
    repeat (5) tick();
    arready = 1'b1;
    tick();
    rd_req = '0;
    tick();
    beats('{0, 0, 1}, '{0, 1, 1});

    // interleaved returns for two channels
    do_reset();
    arready = 1'b1;
    set_req(0, 32'h4000, 8'd3, 3'd2);
    set_req(2, 32'h5000, 8'd1, 3'd2);
    tick(); tick();
    rd_req = '0;
    tick();
    beats('{0, 2, 0, 2, 0, 0}, '{0, 0, 0, 1, 0, 1});
    chk("t4_proto_err", proto_err, 0);

    // early rlast
    do_reset();
    arready = 1'b1;
    set_req(0, 32'h6000, 8'd3, 3'd2);
    tick();
    rd_req = '0;
    tick();
    beats('{0, 0}, '{0, 1});
    chk("t5_early_last", proto_err, 1);

    // beat for an idle channel
    do_reset();
    beats('{3}, '{1});
    chk("t5_stray_beat", proto_err, 1);

    // error response flag
    do_reset();
    arready = 1'b1;
    set_req(1, 32'h7000, 8'd0, 3'd2);
    tick();
    rd_req = '0;
    tick();
    beat(1, 32'hdead_beef, 1'b1, 2'b10);
    tick();
    no_beat();
    tick();

    // reset mid-burst on a WRAP channel, then re-request
    do_reset();
    arready = 1'b1;
    set_req(0, 32'h8010, 8'd3, 3'd2);
    tick();
    rd_req = '0;
    tick();
    beat(0, $urandom, 1'b0, 2'b00);
    tick();
    do_reset();
    arready = 1'b1;
    set_req(0, 32'h9000, 8'd1, 3'd2);
    tick();
    rd_req = '0;
    tick();
    beats('{0, 0}, '{0, 1});

    // randomized traffic with a well-behaved slave
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        rd_req[c] = (cyc < 540) && ($urandom_range(0, 2) == 0);
        rd_addr[c*32 +: 32] = $urandom & 32'hffff_fffc;
        rd_len[c*8 +: 8] = 8'($urandom_range(0, 3));
        rd_size[c*3 +: 3] = 3'($urandom_range(0, 2));
      end
      arready = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int c = 0; c < 4; c++) if (s_act[c]) cand.push_back(c);
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        pick = cand[$urandom_range(0, cand.size() - 1)];
        beat(pick, $urandom, s_sent[pick] == s_len[pick],
             ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
        s_sent[pick]++;
        if (s_sent[pick] > s_len[pick]) s_act[pick] = 0;
      end else begin
        no_beat();
      end
      tick();
    end
    no_beat();
    rd_req = '0;
    tick();
    chk("rand_proto_err", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
